// File: rtl/fft_out_uart_tx_if.sv
// rtl/fft_out_uart_tx_if.sv - word handshake between the FFT output buffer and the UART serializer
//
// Signals:
//   data_valid : data_in holds a buffer word this cycle
//   data_in    : DATA_W-bit word to transmit
//   req_next   : single-cycle request for the next word from the upstream address generator
// Modports:
//   master : upstream buffer side (drives data_valid/data_in, receives req_next)
//   slave  : serializer side
interface fft_out_uart_tx_if #(
    parameter int DATA_W = 32
);
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              req_next;

    modport master (
        output data_valid,
        output data_in,
        input  req_next
    );

    modport slave (
        input  data_valid,
        input  data_in,
        output req_next
    );
endinterface

// File: rtl/fft_out_uart_tx.sv
// rtl/fft_out_uart_tx.sv - serializes FFT buffer words onto an 8N1 UART line, MSB byte first
//
// Parameters:
//   T_1_BIT : clocks per UART bit period (>= 2)
//   DATA_W  : buffer word width, multiple of 8
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of fft_out_uart_tx_if (data_valid, data_in, req_next)
//   tx      : UART serial line, idle high
//   busy    : high while a word is being serialized (every state but IDLE)
//   overrun : sticky, set when data_valid arrives while busy; cleared only by reset
module fft_out_uart_tx #(
    parameter int T_1_BIT = 5207,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_out_uart_tx_if.slave     bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 overrun
);
    localparam int N_BYTES = DATA_W / 8;
    localparam int CNT_W   = (T_1_BIT > 1) ? $clog2(T_1_BIT) : 1;
    localparam int BYTE_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(T_1_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        REQ
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    // The byte on the wire is always the top byte; the register shifts left
    // by one byte at each inter-byte boundary, giving MSB-byte-first order.
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              tx_d, busy_d, req_d, ovr_d;
    logic              req_q;
    logic              bit_end;
    logic [7:0]        top_byte;

    assign bus.req_next = req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            req_q   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            tx      <= tx_d;
            busy    <= busy_d;
            req_q   <= req_d;
            overrun <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        bit_end  = (cnt_q == CNT_LAST);
        // REQ counts as busy, so a word offered alongside req_next is refused too.
        ovr_d    = overrun | (bus.data_valid && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.data_valid) begin
                    sh_d    = bus.data_in;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = REQ;
                    end else begin
                        byte_d  = byte_q + BYTE_W'(1);
                        sh_d    = sh_q << 8;
                        state_d = START;
                    end
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with it; this gives tx its single cycle of latency after data_valid.
        top_byte = sh_d[DATA_W-1 -: 8];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = top_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        req_d  = (state_d == REQ);
    end
endmodule

// File: tb/tb_fft_out_uart_tx.sv
// tb/tb_fft_out_uart_tx.sv - randomized self-checking bench for fft_out_uart_tx
module tb_fft_out_uart_tx;
    localparam int T       = 4;
    localparam int W       = 16;
    localparam int NB      = W / 8;
    localparam int FRAME   = NB * 10 * T;

    logic clk;
    logic rst_n;
    logic tx;
    logic busy;
    logic overrun;

    int errors = 0;
    int checks = 0;
    bit ovr_exp = 1'b0;

    fft_out_uart_tx_if #(.DATA_W(W)) bus ();

    fft_out_uart_tx #(
        .T_1_BIT(T),
        .DATA_W (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .tx     (tx),
        .busy   (busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for cycle c (1-based) of a frame carrying word w.
    function automatic logic model_tx(input logic [W-1:0] w, input int c);
        int          idx;
        int          b;
        int          pos;
        logic [W-1:0] shifted;
        logic [7:0]  byte_val;
        if (c > FRAME) return 1'b1;
        idx      = (c - 1) / T;
        b        = idx / 10;
        pos      = idx % 10;
        shifted  = w >> (8 * (NB - 1 - b));
        byte_val = shifted[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byte_val[pos-1];
    endfunction

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        ovr_exp        = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (bus.req_next !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.req_next); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_ovr got=%b want=0", overrun); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Sends one word and checks the whole frame cycle by cycle. Caller is at a
    // negedge. immediate=1 raises data_valid at this negedge instead of the next.
    // inj_cycle (1..81) offers a different word with data_valid during that cycle.
    task automatic test_word(input logic [W-1:0] w, input bit immediate, input int inj_cycle);
        int req_count = 0;
        if (!immediate) @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_in    = w;
        @(negedge clk);
        for (int c = 1; c <= FRAME + 2; c++) begin
            bus.data_valid = (c == inj_cycle);
            bus.data_in    = W'($urandom);
            if (c == inj_cycle) begin
                if (bus.data_in == w) bus.data_in = ~w;
                ovr_exp = 1'b1;
            end
            if (bus.req_next === 1'b1) req_count++;
            checks++;
            if (tx !== model_tx(w, c)) begin
                errors++; $display("FAIL tx word=%h cycle=%0d got=%b want=%b", w, c, tx, model_tx(w, c));
            end
            checks++;
            if (busy !== (c <= FRAME + 1)) begin
                errors++; $display("FAIL busy word=%h cycle=%0d got=%b want=%b", w, c, busy, (c <= FRAME + 1));
            end
            checks++;
            if (bus.req_next !== (c == FRAME + 1)) begin
                errors++; $display("FAIL req_next word=%h cycle=%0d got=%b want=%b", w, c, bus.req_next, (c == FRAME + 1));
            end
            if (c < FRAME + 2) @(negedge clk);
        end
        bus.data_valid = 1'b0;
        checks++;
        if (req_count != 1) begin errors++; $display("FAIL req_count word=%h got=%0d want=1", w, req_count); end
        checks++;
        if (overrun !== ovr_exp) begin errors++; $display("FAIL overrun word=%h got=%b want=%b", w, overrun, ovr_exp); end
    endtask

    task automatic test_single();
        test_word(16'hA55A, 1'b0, 0);
        for (int i = 0; i < 4; i++) test_word(W'($urandom), 1'b0, 0);
        test_word(16'h0000, 1'b0, 0);
        test_word(16'hFFFF, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) test_word(W'($urandom), 1'b0, 0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_overrun();
        test_word(W'($urandom), 1'b0, 10);
        test_word(W'($urandom), 1'b0, 0);
        test_word(W'($urandom), 1'b0, 0);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    endtask

    task automatic test_reset_midframe();
        int req_count = 0;
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_in    = W'($urandom) | 16'h0100;
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n   = 1'b0;
        ovr_exp = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL midrst_tx got=%b want=1", tx); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_ovr got=%b want=0", overrun); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 10; c++) begin
            @(negedge clk);
            if (bus.req_next === 1'b1) req_count++;
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL midrst_idle cycle=%0d tx=%b busy=%b want tx=1 busy=0", c, tx, busy);
            end
        end
        checks++;
        if (req_count != 0) begin errors++; $display("FAIL midrst_req got=%0d want=0", req_count); end
        test_word(16'h00FF, 1'b0, 0);
    endtask

    task automatic test_req_cycle_edge();
        // Word offered during the req_next cycle is refused; one offered in the
        // first IDLE cycle afterwards is taken.
        test_word(W'($urandom), 1'b0, FRAME + 1);
        test_word(W'($urandom), 1'b1, 0);
        test_word(W'($urandom), 1'b1, 0);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL req_edge_overrun got=%b want=1", overrun); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        test_req_cycle_edge();
        test_reset();
        test_word(W'($urandom), 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
